dp_skid_pipeline_register: RTL and testbench

- Parametrised, handshaked pipeline stage register for the datapath, e.g. EX->WB, generalising the fixed-field stall/flush registers.
- Carries one opaque payload bus: A3, A4, RD2, ALUResult, PCNext packed by the instantiating stage.
- Adds a valid/ready handshake and a 2-entry skid buffer, giving full throughput with registered ready.
- Adds flush with optional payload clearing, occupancy reporting and a saturating count of flushed (killed) instructions.

---
 rtl/dp_skid_pipeline_register.sv | 122 ++++++++++++
 tb/tb_dp_skid_pipeline_register.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dp_skid_pipeline_register.sv
// Handshaked datapath stage register with a 2-entry skid buffer, flush with
// optional payload clearing, occupancy output and a saturating killed-entry count.
module dp_skid_pipeline_register #(
    parameter int unsigned PAYLOAD_W      = 106,
    parameter bit          CLEAR_ON_FLUSH = 1'b1,
    parameter int unsigned KILL_CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic [PAYLOAD_W-1:0]  data_in,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic [PAYLOAD_W-1:0]  data_out,
    input  logic                  stall,
    input  logic                  flush,
    output logic [1:0]            occupancy,
    output logic [KILL_CNT_W-1:0] kill_count,
    input  logic                  kill_count_clr
);

    localparam int unsigned SUM_W = KILL_CNT_W + 1;
    localparam logic [SUM_W-1:0] KILL_MAX = SUM_W'({KILL_CNT_W{1'b1}});

    logic                  main_v_q, main_v_d;
    logic                  skid_v_q, skid_v_d;
    logic [PAYLOAD_W-1:0]  main_d_q, main_d_d;
    logic [PAYLOAD_W-1:0]  skid_d_q, skid_d_d;
    logic                  ready_q, ready_d;
    logic [1:0]            occ_q, occ_d;
    logic [KILL_CNT_W-1:0] kill_q, kill_d;

    logic                  accept_c;
    logic                  consume_c;
    logic [1:0]            kill_inc_c;
    logic [SUM_W-1:0]      kill_sum_c;

    assign accept_c  = valid_in & ready_q & ~flush;
    assign consume_c = main_v_q & ready_in & ~stall;

    // Entry movement between input, main and skid slots; flush overrides all.
    always_comb begin
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        main_d_d = main_d_q;
        skid_d_d = skid_d_q;

        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
            if (CLEAR_ON_FLUSH) begin
                main_d_d = '0;
                skid_d_d = '0;
            end
        end else if (!main_v_q) begin
            if (accept_c) begin
                main_v_d = 1'b1;
                main_d_d = data_in;
            end
        end else if (!skid_v_q) begin
            if (consume_c) begin
                if (accept_c) begin
                    main_d_d = data_in;
                end else begin
                    main_v_d = 1'b0;
                end
            end else if (accept_c) begin
                skid_v_d = 1'b1;
                skid_d_d = data_in;
            end
        end else if (consume_c) begin
            main_d_d = skid_d_q;
            skid_v_d = 1'b0;
        end
    end

    // Ready and occupancy follow the next entry state so both come straight from flops.
    always_comb begin
        ready_d = ~skid_v_d;
        occ_d   = {1'b0, main_v_d} + {1'b0, skid_v_d};
    end

    // A main entry consumed in the flush cycle completed downstream, so it is not killed.
    always_comb begin
        kill_inc_c = {1'b0, main_v_q & ~consume_c} + {1'b0, skid_v_q};
        kill_sum_c = {1'b0, kill_q} + SUM_W'(kill_inc_c);
        kill_d     = kill_q;
        if (kill_count_clr) begin
            kill_d = '0;
        end else if (flush) begin
            kill_d = (kill_sum_c > KILL_MAX) ? KILL_CNT_W'(KILL_MAX) : KILL_CNT_W'(kill_sum_c);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            main_d_q <= '0;
            skid_d_q <= '0;
            ready_q  <= 1'b1;
            occ_q    <= 2'd0;
            kill_q   <= '0;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            main_d_q <= main_d_d;
            skid_d_q <= skid_d_d;
            ready_q  <= ready_d;
            occ_q    <= occ_d;
            kill_q   <= kill_d;
        end
    end

    assign ready_out  = ready_q;
    assign valid_out  = main_v_q;
    assign data_out   = main_d_q;
    assign occupancy  = occ_q;
    assign kill_count = kill_q;

endmodule

// File: tb/tb_dp_skid_pipeline_register.sv
// Scoreboard bench for dp_skid_pipeline_register: directed scenarios then random traffic
// against a queue-based reference model.
module tb_dp_skid_pipeline_register;

    localparam int unsigned PW   = 106;
    localparam int unsigned KW   = 2;
    localparam int          KMAX = (1 << KW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid_in;
    logic          ready_out;
    logic [PW-1:0] data_in;
    logic          valid_out;
    logic          ready_in;
    logic [PW-1:0] data_out;
    logic          stall;
    logic          flush;
    logic [1:0]    occupancy;
    logic [KW-1:0] kill_count;
    logic          kill_count_clr;

    dp_skid_pipeline_register #(
        .PAYLOAD_W      (PW),
        .CLEAR_ON_FLUSH (1'b1),
        .KILL_CNT_W     (KW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_in       (valid_in),
        .ready_out      (ready_out),
        .data_in        (data_in),
        .valid_out      (valid_out),
        .ready_in       (ready_in),
        .data_out       (data_out),
        .stall          (stall),
        .flush          (flush),
        .occupancy      (occupancy),
        .kill_count     (kill_count),
        .kill_count_clr (kill_count_clr)
    );

    always #5 clk = ~clk;

    // Reference model: entries held by the stage in arrival order.
    logic [PW-1:0] exp_q[$];
    int            occ_m;
    int            kill_m;
    logic [PW-1:0] dout_m;
    logic [PW-1:0] last_cons;
    int            errors;
    int            checks;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Monitor: inputs are stable here; a handshake now completes on the next edge.
    always @(negedge clk) begin
        chk("valid_out", 128'(valid_out), 128'(occ_m > 0));
        chk("ready_out", 128'(ready_out), 128'(occ_m < 2));
        chk("occupancy", 128'(occupancy), 128'(occ_m));
        chk("kill_count", 128'(kill_count), 128'(kill_m));
        if (valid_out && ready_in && !stall && !reset) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0h expected none at %0t", data_out, $time);
            end else begin
                last_cons = exp_q.pop_front();
                chk("data_out", 128'(data_out), 128'(last_cons));
            end
        end else if (occ_m == 0) begin
            chk("data_out_idle", 128'(data_out), 128'(dout_m));
        end else if (exp_q.size() > 0) begin
            chk("data_out_hold", 128'(data_out), 128'(exp_q[0]));
        end
    end

    // Advance the model over the edge just taken, then drive the next inputs.
    task automatic step(input logic v, input logic [PW-1:0] d, input logic r,
                        input logic s, input logic f, input logic c);
        int cons;
        int acc;
        int k;
        @(posedge clk);
        #2;
        reset = 1'b0;
        cons = (occ_m > 0 && ready_in && !stall) ? 1 : 0;
        acc  = (valid_in && occ_m < 2 && !flush) ? 1 : 0;
        if (kill_count_clr) begin
            kill_m = 0;
        end else if (flush) begin
            k = occ_m - cons;
            kill_m = (kill_m + k > KMAX) ? KMAX : kill_m + k;
        end
        if (flush) begin
            k = occ_m - cons;
            repeat (k) if (exp_q.size() > 0) void'(exp_q.pop_back());
            occ_m  = 0;
            dout_m = '0;
        end else begin
            occ_m = occ_m - cons + acc;
            if (acc != 0) exp_q.push_back(data_in);
            if (occ_m == 0 && cons != 0) dout_m = last_cons;
        end
        valid_in       = v;
        data_in        = d;
        ready_in       = r;
        stall          = s;
        flush          = f;
        kill_count_clr = c;
    endtask

    task automatic model_clear();
        exp_q.delete();
        occ_m  = 0;
        kill_m = 0;
        dout_m = '0;
    endtask

    task automatic idle(input int n, input logic r);
        repeat (n) step(1'b0, '0, r, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic fill_two(input logic [PW-1:0] a, input logic [PW-1:0] b, input logic s);
        step(1'b1, a, s, s, 1'b0, 1'b0);
        step(1'b1, b, s, s, 1'b0, 1'b0);
    endtask

    logic [PW-1:0] rnd;

    initial begin
        errors = 0;
        checks = 0;
        last_cons = '0;
        model_clear();
        reset = 1'b1;
        valid_in = 1'b0;
        data_in = '0;
        ready_in = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        kill_count_clr = 1'b0;

        // Streaming at one entry per cycle.
        for (int i = 1; i <= 8; i++) step(1'b1, PW'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b1);

        // Backpressure into the skid slot, then drain.
        fill_two(PW'(32'hA), PW'(32'hB), 1'b0);
        idle(2, 1'b0);
        idle(4, 1'b1);

        // Stall with ready_in high behaves like backpressure.
        step(1'b1, PW'(32'hA), 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, PW'(32'hB), 1'b1, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(4, 1'b1);

        // Flush with two held entries while 0xC is offered.
        fill_two(PW'(32'hA), PW'(32'hB), 1'b0);
        step(1'b1, PW'(32'hC), 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3, 1'b1);

        // Counter saturation, then clear racing a flush.
        repeat (3) begin
            fill_two(PW'(32'h11), PW'(32'h22), 1'b0);
            step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        fill_two(PW'(32'h33), PW'(32'h44), 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Asynchronous reset with two entries held, checked before the next edge.
        fill_two(PW'(32'h55), PW'(32'h66), 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        reset = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        kill_count_clr = 1'b0;
        model_clear();
        #1;
        chk("rst_valid_out", 128'(valid_out), 128'(0));
        chk("rst_ready_out", 128'(ready_out), 128'(1));
        chk("rst_data_out", 128'(data_out), 128'(0));
        chk("rst_occupancy", 128'(occupancy), 128'(0));
        idle(2, 1'b1);

        // Random traffic.
        for (int n = 0; n < 800; n++) begin
            rnd = PW'({$urandom, $urandom, $urandom, $urandom});
            step($urandom_range(0, 9) < 7, rnd, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 9) < 2, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 19) == 0);
        end
        idle(4, 1'b1);
        @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
